// File: rtl/spi_link.sv
// spi_link: SPI mode-0 master and slave paired on a single clock.
// Define LSB_FIRST_EN to shift LSB first on both ends.
module spi_link #(
    parameter int CLK_DIV = 1,
    parameter int WIDTH   = 8
) (
    input  logic             CLK_M,
    input  logic             reset,
    input  logic             transmit,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] data_M,
    input  logic             load,
    input  logic [WIDTH-1:0] data_S,
    output logic             MOSI,
    output logic             SCLK,
    output logic             CS,
    output logic             MISO,
    output logic             done_M,
    output logic [WIDTH-1:0] rx_M,
    output logic             done_S,
    output logic [WIDTH-1:0] rx_S
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(2 * WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * WIDTH - 1);
    localparam logic [CW-1:0] BITS      = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XFER,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sclk;
    logic             r_cs;
    logic             r_done_m;
    logic             r_done_s;
    logic [DW-1:0]    r_div;
    logic [HW-1:0]    r_half;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_rx_m;
    logic [WIDTH-1:0] r_stx;
    logic [WIDTH-1:0] r_srx;
    logic [WIDTH-1:0] r_rx_s;
    logic [CW-1:0]    r_scnt;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_start;
    logic             w_end;
    logic             w_cs_rise;
    logic [WIDTH-1:0] w_tx_nx;
    logic [WIDTH-1:0] w_rx_nx;
    logic [WIDTH-1:0] w_stx_nx;
    logic [WIDTH-1:0] w_srx_nx;

`ifdef LSB_FIRST_EN
    assign MOSI     = r_tx[0];
    assign MISO     = r_stx[0];
    assign w_tx_nx  = {1'b0, r_tx[WIDTH-1:1]};
    assign w_rx_nx  = {MISO, r_rx[WIDTH-1:1]};
    assign w_srx_nx = {MOSI, r_srx[WIDTH-1:1]};
    assign w_stx_nx = {r_srx[WIDTH-1], r_stx[WIDTH-1:1]};
`else
    assign MOSI     = r_tx[WIDTH-1];
    assign MISO     = r_stx[WIDTH-1];
    assign w_tx_nx  = {r_tx[WIDTH-2:0], 1'b0};
    assign w_rx_nx  = {r_rx[WIDTH-2:0], MISO};
    assign w_srx_nx = {r_srx[WIDTH-2:0], MOSI};
    assign w_stx_nx = {r_stx[WIDTH-2:0], r_srx[0]};
`endif

    assign SCLK      = r_sclk;
    assign CS        = r_cs;
    assign done_M    = r_done_m;
    assign rx_M      = r_rx_m;
    assign done_S    = r_done_s;
    assign rx_S      = r_rx_s;
    // The slave sees CS release on the same edge the master ends the frame.
    assign w_cs_rise = w_end;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_end   = 1'b0;
        w_tick  = (r_state == S_XFER) && (r_div == DIV_LAST);
        w_rise  = w_tick && !r_sclk;
        w_fall  = w_tick && r_sclk;
        unique case (r_state)
            S_IDLE: begin
                if (transmit) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (!transmit) begin
                    w_next = S_IDLE;
                end else if (d_valid) begin
                    w_next  = S_XFER;
                    w_start = 1'b1;
                end
            end
            S_XFER: begin
                if (w_tick && (r_half == HALF_LAST)) begin
                    w_next = S_DONE;
                    w_end  = 1'b1;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_M) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_sclk   <= 1'b0;
            r_cs     <= 1'b1;
            r_done_m <= 1'b0;
            r_div    <= '0;
            r_half   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_rx_m   <= '0;
        end else begin
            r_state  <= w_next;
            r_done_m <= w_end;
            if (w_start) begin
                r_tx   <= data_M;
                r_cs   <= 1'b0;
                r_sclk <= 1'b0;
                r_div  <= '0;
                r_half <= '0;
            end
            if (r_state == S_XFER) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_sclk <= ~r_sclk;
                    r_half <= r_half + 1'b1;
                end
            end
            if (w_rise) r_rx <= w_rx_nx;
            if (w_fall) r_tx <= w_tx_nx;
            if (w_end) begin
                r_cs   <= 1'b1;
                r_rx_m <= r_rx;
            end
        end
    end

    // Slave tx register refills with received bits, so it echoes by default.
    always_ff @(posedge CLK_M) begin
        if (!reset) begin
            r_stx    <= '0;
            r_srx    <= '0;
            r_scnt   <= '0;
            r_rx_s   <= '0;
            r_done_s <= 1'b0;
        end else begin
            r_done_s <= 1'b0;
            if (r_cs) begin
                r_scnt <= '0;
                if (load) r_stx <= data_S;
            end else begin
                if (w_rise) begin
                    r_srx  <= w_srx_nx;
                    r_scnt <= r_scnt + 1'b1;
                end
                if (w_fall) r_stx <= w_stx_nx;
                if (w_cs_rise && (r_scnt == BITS)) begin
                    r_rx_s   <= r_srx;
                    r_done_s <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_link.sv
// tb_spi_link: vector table, random frames against a byte-level model,
// and hand sequences for abort, LOAD timing and CLK_DIV=4.
module tb_spi_link;
    logic       clk;
    logic       reset;
    logic       transmit, d_valid, load;
    logic [7:0] data_M, data_S;
    logic       mosi, sclk, cs, miso, done_m, done_s;
    logic [7:0] rx_m, rx_s;
    logic       b_transmit, b_d_valid, b_load;
    logic [7:0] b_data_M, b_data_S;
    logic       b_mosi, b_sclk, b_cs, b_miso, b_done_m, b_done_s;
    logic [7:0] b_rx_m, b_rx_s;

    int total = 0;
    int bad   = 0;

    spi_link #(.CLK_DIV(1), .WIDTH(8)) u_d1 (
        .CLK_M(clk), .reset(reset),
        .transmit(transmit), .d_valid(d_valid), .data_M(data_M),
        .load(load), .data_S(data_S),
        .MOSI(mosi), .SCLK(sclk), .CS(cs), .MISO(miso),
        .done_M(done_m), .rx_M(rx_m), .done_S(done_s), .rx_S(rx_s)
    );

    spi_link #(.CLK_DIV(4), .WIDTH(8)) u_d4 (
        .CLK_M(clk), .reset(reset),
        .transmit(b_transmit), .d_valid(b_d_valid), .data_M(b_data_M),
        .load(b_load), .data_S(b_data_S),
        .MOSI(b_mosi), .SCLK(b_sclk), .CS(b_cs), .MISO(b_miso),
        .done_M(b_done_m), .rx_M(b_rx_m), .done_S(b_done_s), .rx_S(b_rx_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dm;
        logic [7:0] ds;
        bit         ld;
        int         dly;
        bit         mid;
        logic [7:0] exp_m;
        logic [7:0] exp_s;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Order in which a byte's bits appear on the wire, packed MSB-first.
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
`ifdef LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic frame(input logic [7:0] dm, input logic [7:0] ds,
                         input bit ld, input int dly, input bit mid,
                         input logic [7:0] exp_m, input logic [7:0] exp_s);
        logic [7:0] mo, mi;
        int         k, rises, cs_bad, idle_bad;
        logic       prev;
        mo = '0; mi = '0; k = 0; rises = 0; cs_bad = 0; idle_bad = 0;
        @(negedge clk);
        transmit = 1'b1;
        @(negedge clk);
        data_M = dm; data_S = ds; load = ld;
        d_valid = (dly == 0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (cs !== 1'b1 || sclk !== 1'b0) idle_bad++;
        end
        if (dly > 0) check("load wait idle", idle_bad, 0);
        d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0; load = 1'b0; transmit = 1'b0;
        check("xfer start cs", cs, 0);
        prev = sclk;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (mid) begin
                load = (k == 6);
                if (k == 6) data_S = 8'h55;
            end
            if (done_m) break;
            if (cs !== 1'b0) cs_bad++;
            if (sclk && !prev) begin
                rises++;
                mo = {mo[6:0], mosi};
                mi = {mi[6:0], miso};
            end
            prev = sclk;
        end
        load = 1'b0;
        check("done latency", k, 16);
        check("sclk rises", rises, 8);
        check("cs low in frame", cs_bad, 0);
        check("mosi bits", mo, wire_order(dm));
        check("miso bits", mi, wire_order(exp_m));
        check("done_S with done_M", done_s, 1);
        check("cs at done", {cs, sclk}, 2'b10);
        check("rx_M", rx_m, exp_m);
        check("rx_S", rx_s, exp_s);
        @(negedge clk);
        check("done pulse width", {done_m, done_s}, 2'b00);
    endtask

    initial begin
        vec_t       vt[7];
        logic [7:0] sb, dm, ds, em;
        bit         ld, mid;
        int         dly, k, rises, run, runbad, pulses, cs_bad;
        logic       prev;

        vt[0] = '{8'hB3, 8'hCA, 1, 0, 0, 8'hCA, 8'hB3};
        vt[1] = '{8'hFF, 8'h00, 1, 0, 0, 8'h00, 8'hFF};
        vt[2] = '{8'h00, 8'hFF, 1, 0, 0, 8'hFF, 8'h00};
        vt[3] = '{8'h3C, 8'h99, 0, 0, 0, 8'h00, 8'h3C};
        vt[4] = '{8'h81, 8'h7E, 1, 5, 0, 8'h7E, 8'h81};
        vt[5] = '{8'h5A, 8'hA5, 1, 0, 1, 8'hA5, 8'h5A};
        vt[6] = '{8'h12, 8'h66, 0, 0, 1, 8'h5A, 8'h12};

        reset = 1'b0;
        transmit = 0; d_valid = 0; load = 0; data_M = 0; data_S = 0;
        b_transmit = 0; b_d_valid = 0; b_load = 0;
        b_data_M = 0; b_data_S = 0;
        repeat (2) @(negedge clk);
        check("reset lines", {mosi, sclk, cs, miso, done_m, done_s},
              6'b001000);
        check("reset rx", {rx_m, rx_s}, 16'h0000);
        check("reset lines div4", {b_mosi, b_sclk, b_cs, b_miso,
              b_done_m, b_done_s}, 6'b001000);
        reset = 1'b1;

        foreach (vt[i])
            frame(vt[i].dm, vt[i].ds, vt[i].ld, vt[i].dly, vt[i].mid,
                  vt[i].exp_m, vt[i].exp_s);

        // Model: slave sends its loaded byte, else echoes the last master byte.
        sb = 8'h12;
        for (int n = 0; n < 12; n++) begin
            dm  = 8'($urandom);
            ds  = 8'($urandom);
            ld  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 3);
            mid = 1'($urandom_range(0, 1));
            em  = ld ? ds : sb;
            frame(dm, ds, ld, dly, mid, em, dm);
            sb = dm;
        end

        // transmit dropped in LOAD: back to IDLE, later d_valid ignored
        @(negedge clk);
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        @(negedge clk);
        d_valid = 1'b1;
        cs_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (cs !== 1'b1 || sclk !== 1'b0) cs_bad++;
        end
        d_valid = 1'b0;
        check("load abort stays idle", cs_bad, 0);

        // reset at the 4th SCLK rise aborts the frame
        @(negedge clk);
        transmit = 1'b1;
        @(negedge clk);
        data_M = 8'hC3; data_S = 8'h96; load = 1'b1; d_valid = 1'b1;
        @(negedge clk);
        transmit = 1'b0; d_valid = 1'b0; load = 1'b0;
        rises = 0; k = 0; prev = sclk;
        while (rises < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        check("abort reached 4 rises", rises, 4);
        reset = 1'b0;
        @(negedge clk);
        check("abort cs/sclk", {cs, sclk}, 2'b10);
        check("abort rx cleared", {rx_m, rx_s}, 16'h0000);
        reset = 1'b1;
        pulses = 0;
        repeat (20) begin
            if (done_m || done_s) pulses++;
            @(negedge clk);
        end
        check("abort no done", pulses, 0);
        frame(8'h69, 8'h96, 1, 0, 0, 8'h96, 8'h69);

        // CLK_DIV=4: 4-cycle SCLK phases, done 64 cycles after first XFER
        @(negedge clk);
        b_transmit = 1'b1;
        @(negedge clk);
        b_data_M = 8'hB3; b_data_S = 8'hCA; b_load = 1'b1; b_d_valid = 1'b1;
        @(negedge clk);
        b_transmit = 1'b0; b_d_valid = 1'b0; b_load = 1'b0;
        check("div4 xfer start cs", b_cs, 0);
        prev = b_sclk; run = 1; runbad = 0; rises = 0; k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (b_done_m) break;
            if (b_sclk !== prev) begin
                if (run != 4) runbad++;
                run = 1;
                if (b_sclk) rises++;
            end else begin
                run++;
            end
            prev = b_sclk;
        end
        if (run != 4) runbad++;
        check("div4 done latency", k, 64);
        check("div4 phase length", runbad, 0);
        check("div4 sclk rises", rises, 8);
        check("div4 done_S", b_done_s, 1);
        check("div4 rx_M", b_rx_m, 8'hCA);
        check("div4 rx_S", b_rx_s, 8'hB3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
